// File: rtl/clint_mc_pkg.sv
// Shared definitions for the multi-source local interrupt controller:
// FSM encodings, CSR addresses, instruction words and mstatus bit positions.
package clint_mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MEPC      = 3'd1,
        S_MSTATUS   = 3'd2,
        S_MCAUSE    = 3'd3,
        S_JUMP      = 3'd4,
        S_MRET_ST   = 3'd5,
        S_MRET_JUMP = 3'd6
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int CAUSE_ECALL  = 11;
    localparam int CAUSE_EBREAK = 3;

    // Source index width; a single source still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_mc_if.sv
// Bundle of everything the controller exchanges with the pipeline:
// interrupt lines, writeback info, CSR reads, CSR write port and redirect.
interface clint_mc_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 8,
    parameter int CSR_AW  = 12
);
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] irq_mask_i;
    logic               wb_valid_i;
    logic [XLEN-1:0]    wb_inst_i;
    logic [XLEN-1:0]    wb_inst_addr_i;
    logic [XLEN-1:0]    next_pc_i;
    logic [XLEN-1:0]    csr_mtvec_i;
    logic [XLEN-1:0]    csr_mepc_i;
    logic [XLEN-1:0]    csr_mstatus_i;
    logic               csr_we_o;
    logic [CSR_AW-1:0]  csr_waddr_o;
    logic [XLEN-1:0]    csr_wdata_o;
    logic               hold_o;
    logic               int_assert_o;
    logic [XLEN-1:0]    int_addr_o;
    logic [NUM_IRQ-1:0] irq_ack_o;

    modport master (
        output irq_i, irq_mask_i, wb_valid_i, wb_inst_i, wb_inst_addr_i, next_pc_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o, irq_ack_o
    );

    modport slave (
        input  irq_i, irq_mask_i, wb_valid_i, wb_inst_i, wb_inst_addr_i, next_pc_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o, irq_ack_o
    );
endinterface

// File: rtl/clint_mc_irq_pend_arb.sv
// Per-source pending state and fixed-priority pick: edge sources latch a
// rising edge until the trap for them is entered, level sources follow the
// line directly; the lowest eligible index wins.
module irq_pend_arb #(
    parameter int                 NUM_IRQ  = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
    parameter int                 IDX_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               mie,
    input  logic               clr,
    input  logic [IDX_W-1:0]   clr_idx,
    output logic               vld,
    output logic [IDX_W-1:0]   idx
);
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] clr_vec;

    assign clr_vec = NUM_IRQ'(clr) << clr_idx;
    assign pend    = (IRQ_EDGE & pend_q) | (~IRQ_EDGE & irq);
    assign elig    = pend & mask & {NUM_IRQ{mie}};

    // Edge history and sticky pending bits; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d  <= '0;
            pend_q <= '0;
        end else begin
            irq_d  <= irq;
            pend_q <= IRQ_EDGE & ((irq & ~irq_d) | (pend_q & ~clr_vec));
        end
    end

    // Lowest-index priority encoder over the eligible sources.
    always_comb begin
        vld = |elig;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/clint_mc.sv
// Multi-source local interrupt controller: picks among sync exceptions, mret
// and masked external interrupts, writes mepc/mstatus/mcause one per cycle
// and then redirects the pipeline.
module clint_mc
    import clint_mc_pkg::*;
#(
    parameter int                 XLEN          = 32,
    parameter int                 NUM_IRQ       = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE      = '0,
    parameter int                 IRQ_CODE_BASE = 16,
    parameter int                 CSR_AW        = 12
) (
    input  logic      clk,
    input  logic      rst,
    clint_mc_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_IRQ);

    state_t             state_q, state_d;
    logic               arb_vld;
    logic [IDX_W-1:0]   arb_idx;
    logic               is_sync, is_ebreak, is_mret;
    logic               take, take_async;
    logic               pend_clr;

    logic [XLEN-1:0]    cause_q, mepc_q, mstatus_q, mtvec_q;
    logic [IDX_W-1:0]   idx_q;
    logic               async_q;

    logic               csr_we;
    logic [CSR_AW-1:0]  csr_waddr;
    logic [XLEN-1:0]    csr_wdata;
    logic               int_assert;
    logic [XLEN-1:0]    int_addr;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [XLEN-1:0]    ms_wdata;
    logic [XLEN-1:0]    tvec_base;

    assign is_ebreak  = bus.wb_inst_i == XLEN'(INST_EBREAK);
    assign is_sync    = bus.wb_valid_i & ((bus.wb_inst_i == XLEN'(INST_ECALL)) | is_ebreak);
    assign is_mret    = bus.wb_valid_i & (bus.wb_inst_i == XLEN'(INST_MRET));
    assign take_async = ~is_sync & ~is_mret & arb_vld;
    assign pend_clr   = (state_q == S_MEPC) & async_q;
    assign tvec_base  = {mtvec_q[XLEN-1:2], 2'b00};

    irq_pend_arb #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_EDGE (IRQ_EDGE),
        .IDX_W    (IDX_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .irq      (bus.irq_i),
        .mask     (bus.irq_mask_i),
        .mie      (bus.csr_mstatus_i[MSTATUS_MIE]),
        .clr      (pend_clr),
        .clr_idx  (idx_q),
        .vld      (arb_vld),
        .idx      (arb_idx)
    );

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: decisions only in IDLE, sync > mret > async.
    always_comb begin
        state_d = S_IDLE;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rst && (is_sync || take_async)) begin
                    state_d = S_MEPC;
                    take    = 1'b1;
                end else if (!rst && is_mret) begin
                    state_d = S_MRET_ST;
                    take    = 1'b1;
                end
            end
            S_MEPC:      state_d = S_MSTATUS;
            S_MSTATUS:   state_d = S_MCAUSE;
            S_MCAUSE:    state_d = S_JUMP;
            S_MRET_ST:   state_d = S_MRET_JUMP;
            default:     state_d = S_IDLE;
        endcase
    end

    // Snapshot of everything the sequence needs, taken in the decision cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q   <= '0;
            mepc_q    <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            idx_q     <= '0;
            async_q   <= 1'b0;
        end else if (take) begin
            mstatus_q <= bus.csr_mstatus_i;
            mtvec_q   <= bus.csr_mtvec_i;
            idx_q     <= arb_idx;
            async_q   <= take_async;
            if (take_async) begin
                cause_q <= {1'b1, (XLEN-1)'(IRQ_CODE_BASE) + (XLEN-1)'(arb_idx)};
                mepc_q  <= bus.next_pc_i;
            end else begin
                cause_q <= is_ebreak ? XLEN'(CAUSE_EBREAK) : XLEN'(CAUSE_ECALL);
                mepc_q  <= bus.wb_inst_addr_i;
            end
        end
    end

    // Output decode from the registered state and snapshot.
    always_comb begin
        csr_we     = 1'b0;
        csr_waddr  = '0;
        csr_wdata  = '0;
        int_assert = 1'b0;
        int_addr   = '0;
        irq_ack    = '0;
        ms_wdata   = mstatus_q;
        case (state_q)
            S_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MEPC);
                csr_wdata = mepc_q;
                if (async_q) irq_ack = NUM_IRQ'(1) << idx_q;
            end
            S_MSTATUS: begin
                ms_wdata[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
                ms_wdata[MSTATUS_MIE]  = 1'b0;
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = ms_wdata;
            end
            S_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MCAUSE);
                csr_wdata = cause_q;
            end
            S_JUMP: begin
                int_assert = 1'b1;
                // Vectored mode only for interrupts; modes 2/3 behave as direct.
                if (async_q && mtvec_q[1:0] == 2'b01)
                    int_addr = tvec_base + {cause_q[XLEN-3:0], 2'b00};
                else
                    int_addr = tvec_base;
            end
            S_MRET_ST: begin
                ms_wdata[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
                ms_wdata[MSTATUS_MPIE] = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = ms_wdata;
            end
            S_MRET_JUMP: begin
                int_assert = 1'b1;
                int_addr   = bus.csr_mepc_i;
            end
            default: ;
        endcase
    end

    assign bus.csr_we_o     = csr_we;
    assign bus.csr_waddr_o  = csr_waddr;
    assign bus.csr_wdata_o  = csr_wdata;
    assign bus.int_assert_o = int_assert;
    assign bus.int_addr_o   = int_addr;
    assign bus.irq_ack_o    = irq_ack;
    assign bus.hold_o       = (state_q != S_IDLE) | take;

endmodule

// File: doc/clint_mc.md
Name: clint_mc

Overview:
- Parametrised multi-source successor of the core's single-source local interrupt controller.
- Arbitrates among NUM_IRQ external interrupt lines, each individually maskable and each level- or edge-sensitive, plus ecall/ebreak/mret retiring in writeback.
- Writes mepc/mstatus/mcause through a single CSR write port, then redirects the pipeline via flow_ctrl.
- Adds per-source pending latches, fixed priority, an acknowledge output and vectored mtvec mode.

Parameters:
XLEN, 32, data/address width
NUM_IRQ, 8, number of external interrupt lines (1..16)
IRQ_EDGE, {NUM_IRQ{1'b0}}, bit i=1: source i rising-edge sensitive, 0: level
IRQ_CODE_BASE, 16, mcause exception code of source 0 (source i -> IRQ_CODE_BASE+i)
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  reset
irq_i  in  NUM_IRQ  raw interrupt lines, already synchronous to clk
irq_mask_i  in  NUM_IRQ  per-source enable (mie bits)
wb_valid_i  in  1  writeback stage holds a retiring instruction
wb_inst_i  in  XLEN  writeback instruction word
wb_inst_addr_i  in  XLEN  writeback instruction address
next_pc_i  in  XLEN  address of oldest unretired instruction; this is the async mepc
csr_mtvec_i  in  XLEN  mtvec
csr_mepc_i  in  XLEN  mepc
csr_mstatus_i  in  XLEN  mstatus
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  CSR_AW  CSR write address
csr_wdata_o  out  XLEN  CSR write data
hold_o  out  1  pipeline hold to flow_ctrl
int_assert_o  out  1  one-cycle redirect pulse
int_addr_o  out  XLEN  redirect target
irq_ack_o  out  NUM_IRQ  one-hot, one-cycle acknowledge of the taken source

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - Pending latches, irq_i delay register and all captured registers clear to 0.
  - Every output is 0.
  - Reset asserted mid-sequence aborts the sequence: no further CSR writes and no redirect.
- Pending:
  - Edge source: pend[i] is set when irq_i[i] & ~irq_d[i]. It is cleared in the S_MEPC cycle when i is the taken source. If a set and a clear coincide, set wins.
  - Level source: pend[i] = irq_i[i] (no latch).
- Eligibility and priority:
  - elig = pend & irq_mask_i & {NUM_IRQ{mstatus[3]}}.
  - Lowest index wins.
- Decision, made in IDLE only, with priority sync > mret > async:
  - SYNC: wb_valid_i and wb_inst_i is ECALL (cause 11) or EBREAK (cause 3); mepc = wb_inst_addr_i.
  - MRET: wb_valid_i and wb_inst_i is MRET.
  - ASYNC: |elig. cause = {1'b1, (IRQ_CODE_BASE+idx) zero-extended to XLEN-1 bits}; mepc = next_pc_i.
  - hold_o = (state!=IDLE) | decision_taken, combinational, so it is high in the decision cycle T.
  - At T the block latches cause, mepc, idx, csr_mstatus_i and csr_mtvec_i.
- Trap sequence: IDLE(T) -> S_MEPC(T+1) -> S_MSTATUS(T+2) -> S_MCAUSE(T+3) -> S_JUMP(T+4) -> IDLE.
  - S_MEPC: we=1, waddr=MEPC, wdata=latched mepc. irq_ack_o[idx]=1 if the trap is ASYNC.
  - S_MSTATUS: we=1, waddr=MSTATUS, wdata = latched mstatus with bit7 (MPIE) = old bit3 (MIE) and bit3 = 0.
  - S_MCAUSE: we=1, waddr=MCAUSE, wdata=cause.
  - S_JUMP: int_assert_o=1. int_addr_o = {mtvec[XLEN-1:2],2'b00} + 4*code when mtvec[1:0]==2'b01 and the trap is ASYNC; otherwise {mtvec[XLEN-1:2],2'b00}. mtvec modes 2/3 are treated as direct.
- Mret sequence: IDLE(T) -> S_MRET_ST(T+1) -> S_MRET_JUMP(T+2) -> IDLE.
  - S_MRET_ST: we=1, waddr=MSTATUS, wdata = latched mstatus with bit3 = old bit7 and bit7 = 1.
  - S_MRET_JUMP: int_assert_o=1, int_addr_o = csr_mepc_i.
- Output decoding: all outputs except hold_o are decoded from the registered state and latched values. In non-listed cycles they are 0.
- Inputs outside IDLE: wb and irq inputs are ignored for decisions. Edge detection and pend setting continue.
- Back-to-back events: at least one IDLE cycle separates sequences. Because mstatus.MIE=0 after trap entry, no async nesting occurs.
- Undefined state encodings recover to IDLE.

Decomposition:
- Shared defines package holds:
  - state encodings;
  - CSR addresses: MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342;
  - INST_ECALL 32'h00000073, INST_EBREAK 32'h00100073, INST_MRET 32'h30200073;
  - mstatus bit indices MIE=3, MPIE=7;
  - cause codes 11 and 3.
- One sub-module, irq_pend_arb: edge detect, pending latches, masking, lowest-index priority encoder. Outputs are valid flag and idx.

Test Plan:
- ECALL retires at 0x100, mstatus=0x8, mtvec=0x400 -> T+1 MEPC<=0x100; T+2 MSTATUS<=0x80; T+3 MCAUSE<=11; T+4 int_assert_o with addr 0x400; hold_o high T..T+4.
- irq_i[5]=1 and irq_i[2]=1 together, mask 0xFF, MIE=1, mtvec=0x401, next_pc_i=0x200 -> source 2 taken; MEPC<=0x200; MCAUSE<=0x80000012; addr 0x448; irq_ack_o=0x04 at T+1.
- Edge source 3 pulses 1 cycle while MIE=0 -> pend held; MIE later set -> trap taken and pend cleared. Level source 4 drops before MIE set -> no trap.
- MRET retires, mstatus=0x80, mepc=0x300 -> T+1 MSTATUS<=0x88; T+2 int_assert_o with addr 0x300; hold_o high T..T+2.
- EBREAK in writeback with eligible irq 0 in the same cycle -> MCAUSE<=3. Irq 0 is not taken until after the handler's MRET restores MIE.
- rst raised at S_MSTATUS -> next cycle all outputs 0, no redirect, pend cleared.
